// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage sitting directly in front of a synchronous imem
//   with a 1-cycle read latency. It owns the program counter, drives the imem
//   read address, and captures the returned word into an IF/ID register.
//   Decode back-pressure (Stall) freezes the IF/ID register and the fetch
//   state; a taken branch (BranchTaken) redirects fetch and squashes the
//   wrong-path word that is already in flight, costing one bubble.
//
// Ports
//   clk           in   1       rising-edge clock
//   reset         in   1       synchronous, active-high reset
//   Address       out  ADDR_W  imem read address (combinational)
//   Instruction   in   DATA_W  imem read data for the address of the last edge
//   Stall         in   1       decode cannot accept; hold outputs and fetch state
//   BranchTaken   in   1       redirect fetch to BranchTarget this cycle
//   BranchTarget  in   ADDR_W  redirect address
//   InstrOut      out  DATA_W  IF/ID instruction register
//   PCOut         out  ADDR_W  address InstrOut was fetched from
//   InstrValid    out  1       InstrOut/PCOut hold a valid, non-squashed word
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned           ADDR_W   = 3,
  parameter int unsigned           DATA_W   = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Instruction,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic [DATA_W-1:0] InstrOut,
  output logic [ADDR_W-1:0] PCOut,
  output logic              InstrValid
);

  // Fetch-side state: next address to issue and the read currently in flight.
  logic [ADDR_W-1:0] pc_q,        pc_d;
  logic [ADDR_W-1:0] req_pc_q,    req_pc_d;
  logic              req_valid_q, req_valid_d;

  // Output-side (IF/ID) state.
  logic [DATA_W-1:0] instr_q,     instr_d;
  logic [ADDR_W-1:0] pc_out_q,    pc_out_d;
  logic              valid_q,     valid_d;

  // imem address mux. While stalled the in-flight read is re-issued so the
  // word imem returns next cycle is still the one the IF/ID register is owed.
  always_comb begin
    Address = pc_q;
    if (reset) begin
      Address = RESET_PC;
    end else if (BranchTaken) begin
      Address = BranchTarget;
    end else if (Stall) begin
      if (req_valid_q) begin
        Address = req_pc_q;
      end else begin
        Address = pc_q;
      end
    end else begin
      Address = pc_q;
    end
  end

  // Fetch-side next state. A branch redirects even while stalled so the
  // target read is already outstanding when decode releases the stall.
  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    if (BranchTaken) begin
      req_pc_d    = BranchTarget;
      req_valid_d = 1'b1;
      pc_d        = BranchTarget + ADDR_W'(1);
    end else if (Stall) begin
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      req_valid_d = req_valid_q;
    end else begin
      req_pc_d    = pc_q;
      req_valid_d = 1'b1;
      pc_d        = pc_q + ADDR_W'(1);
    end
  end

  // Output-side next state. A branch without stall drops the in-flight
  // wrong-path word by clearing valid; data and PC are left as they were.
  always_comb begin
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    if (Stall) begin
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      valid_d  = valid_q;
    end else if (BranchTaken) begin
      valid_d  = 1'b0;
    end else begin
      instr_d  = Instruction;
      pc_out_d = req_pc_q;
      valid_d  = req_valid_q;
    end
  end

  // State registers with synchronous reset. Reset also counts as issuing
  // RESET_PC, since imem latches RESET_PC on the reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC + ADDR_W'(1);
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b1;
      instr_q     <= {DATA_W{1'b0}};
      pc_out_q    <= {ADDR_W{1'b0}};
      valid_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      valid_q     <= valid_d;
    end
  end

  assign InstrOut   = instr_q;
  assign PCOut      = pc_out_q;
  assign InstrValid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Drives fetch_unit against a behavioural imem (words[i] = 10*(i+1)).
//   The reference model views the stage as a delivery stream: it only tracks
//   which address is owed to decode next and what the IF/ID register shows.
//   Expected per-cycle outputs are queued by the stimulus process and popped
//   and compared by an independent monitor.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;
  localparam int          NWORDS = 8;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] Instruction;
  logic              Stall;
  logic              BranchTaken;
  logic [ADDR_W-1:0] BranchTarget;
  logic [DATA_W-1:0] InstrOut;
  logic [ADDR_W-1:0] PCOut;
  logic              InstrValid;

  fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_PC (3'd0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Address      (Address),
    .Instruction  (Instruction),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .InstrOut     (InstrOut),
    .PCOut        (PCOut),
    .InstrValid   (InstrValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word_at(input int addr);
    return DATA_W'(10 * (addr + 1));
  endfunction

  // imem with a registered read port.
  initial Instruction = '0;
  always @(posedge clk) Instruction <= word_at(int'(Address));

  typedef struct {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  int vectors;
  int miscompares;

  // Reference model state.
  int              m_next;   // address whose word decode is owed next
  logic            m_valid;
  int              m_pc;
  logic [DATA_W-1:0] m_data;

  // One cycle of stimulus; the expected post-edge outputs are queued.
  task automatic cycle(input logic r, input logic s, input logic b, input int t);
    exp_t e;
    @(negedge clk);
    reset        = r;
    Stall        = s;
    BranchTaken  = b;
    BranchTarget = ADDR_W'(t);
    if (r) begin
      m_next  = 0;
      m_valid = 1'b0;
      m_pc    = 0;
      m_data  = '0;
    end else begin
      if (b) m_next = t;
      if (!s) begin
        if (b) begin
          m_valid = 1'b0;
        end else begin
          m_valid = 1'b1;
          m_pc    = m_next;
          m_data  = word_at(m_next);
          m_next  = (m_next + 1) % NWORDS;
        end
      end
    end
    e.valid = m_valid;
    e.pc    = ADDR_W'(m_pc);
    e.data  = m_data;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0);
  endtask

  // Monitor: compares every cycle's outputs against the queued expectation.
  initial begin
    exp_t e;
    vectors     = 0;
    miscompares = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (InstrValid !== e.valid || PCOut !== e.pc || InstrOut !== e.data) begin
          miscompares++;
          $display("FAIL ifid_out @%0t: got valid=%b pc=%0d instr=%0d, required valid=%b pc=%0d instr=%0d",
                   $time, InstrValid, PCOut, InstrOut, e.valid, e.pc, e.data);
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    Stall        = 1'b0;
    BranchTaken  = 1'b0;
    BranchTarget = '0;
    m_next  = 0;
    m_valid = 1'b0;
    m_pc    = 0;
    m_data  = '0;

    // Reset, then a straight run through the address wrap.
    cycle(1'b1, 1'b0, 1'b0, 0);
    run(11);
    // Stall for 3 cycles, then release.
    cycle(1'b1, 1'b0, 1'b0, 0);
    run(3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 0);
    run(3);
    // Taken branch to 6 (wraps afterwards).
    cycle(1'b1, 1'b0, 1'b0, 0);
    run(2);
    cycle(1'b0, 1'b0, 1'b1, 6);
    run(4);
    // Branch together with stall, stall held one more cycle.
    cycle(1'b1, 1'b0, 1'b0, 0);
    run(5);
    cycle(1'b0, 1'b1, 1'b1, 1);
    cycle(1'b0, 1'b1, 1'b0, 0);
    run(3);
    // Reset in the middle of a stall and in the middle of a branch.
    cycle(1'b0, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b0, 0);
    run(3);
    cycle(1'b0, 1'b0, 1'b1, 4);
    cycle(1'b1, 1'b0, 1'b1, 5);
    run(3);
    // Back-to-back branches: 3 must never become valid.
    cycle(1'b0, 1'b0, 1'b1, 3);
    cycle(1'b0, 1'b0, 1'b1, 5);
    run(4);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      logic r, s, b;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 25);
      b = ($urandom_range(0, 99) < 15);
      cycle(r, s, b, int'($urandom_range(0, NWORDS - 1)));
    end
    run(2);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
